// File: rtl/mminmax_stream.sv
// -----------------------------------------------------------------------------
// mminmax_stream
//
// Streaming extremum finder. A frame of up to DEPTH samples arrives over a
// valid/ready input. The block tracks either the minimum or the maximum of the
// frame together with the 0-based position of that extremum, then presents the
// result on a valid/ready output and holds it until it is taken.
//
// The frame ends on the sample flagged with in_last, or implicitly on the
// DEPTH-th sample. Ties keep the earliest index. The mode (min or max) is
// latched from smin/smax together with the first sample of a frame; it selects
// max only when smax=1 and smin=0, and min otherwise.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous reset, active-low
//   smin       in   1       select minimum (sampled with first sample)
//   smax       in   1       select maximum (sampled with first sample)
//   in_valid   in   1       sample valid
//   in_ready   out  1       block can accept a sample (low while holding)
//   in_data    in   WIDTH   sample
//   in_last    in   1       final sample of the frame
//   out_valid  out  1       result valid, held until accepted
//   out_ready  in   1       downstream accepts result
//   res_high   out  WIDTH   upper result half, always zero
//   res_low    out  WIDTH   extremum value of the frame
//   res_idx    out  IDXW    0-based position of the extremum
//   res_cnt    out  IDXW+1  number of samples in the frame (1..DEPTH)
// -----------------------------------------------------------------------------
module mminmax_stream #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int SIGNED = 0,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smin,
  input  logic              smax,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  res_high,
  output logic [WIDTH-1:0]  res_low,
  output logic [IDXW-1:0]   res_idx,
  output logic [IDXW:0]     res_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [IDXW:0] L_DEPTH = (IDXW+1)'(DEPTH);

  // Strict improvement test: a candidate replaces the running extremum only
  // when it is strictly smaller (min) or strictly larger (max), so ties keep
  // the earliest index.
  function automatic logic f_better(input logic [WIDTH-1:0] cand,
                                    input logic [WIDTH-1:0] cur,
                                    input logic             mode_max);
    logic gt;
    logic lt;
    if (SIGNED != 0) begin
      gt = $signed(cand) > $signed(cur);
      lt = $signed(cand) < $signed(cur);
    end else begin
      gt = cand > cur;
      lt = cand < cur;
    end
    return mode_max ? gt : lt;
  endfunction

  // Working state for the frame in progress
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_ext;
  logic [IDXW-1:0]  r_idx;
  logic [IDXW:0]    r_cnt;
  logic             r_mode_max;

  // Result registers: kept separate from the working state so the outputs
  // keep the last delivered result while a new frame accumulates.
  logic [WIDTH-1:0] r_res_low;
  logic [IDXW-1:0]  r_res_idx;
  logic [IDXW:0]    r_res_cnt;

  logic             w_accept;
  logic             w_deliver;
  logic [IDXW:0]    w_cnt_inc;
  logic             w_better;
  logic [WIDTH-1:0] w_ext_nxt;
  logic [IDXW-1:0]  w_idx_nxt;
  logic [IDXW:0]    w_cnt_nxt;
  logic             w_end;

  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = (r_state == S_HOLD);
  assign res_high  = '0;
  assign res_low   = r_res_low;
  assign res_idx   = r_res_idx;
  assign res_cnt   = r_res_cnt;

  assign w_accept  = in_valid & in_ready;
  assign w_deliver = out_valid & out_ready;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_better  = f_better(in_data, r_ext, r_mode_max);

  // Candidate working state if the current input sample is accepted.
  // The first sample of a frame seeds the extremum unconditionally.
  always_comb begin
    w_ext_nxt = r_ext;
    w_idx_nxt = r_idx;
    w_cnt_nxt = r_cnt;
    w_end     = 1'b0;
    if (r_state == S_IDLE) begin
      w_ext_nxt = in_data;
      w_idx_nxt = '0;
      w_cnt_nxt = (IDXW+1)'(1);
      w_end     = in_last;
    end else begin
      w_cnt_nxt = w_cnt_inc;
      if (w_better) begin
        w_ext_nxt = in_data;
        // The new sample's position equals the count of samples seen so far;
        // in ACC that count is always below DEPTH, so it fits in IDXW bits.
        w_idx_nxt = r_cnt[IDXW-1:0];
      end
      // Implicit frame end when the DEPTH-th sample is taken
      w_end = in_last | (w_cnt_inc == L_DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ext      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_mode_max <= 1'b0;
      r_res_low  <= '0;
      r_res_idx  <= '0;
      r_res_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_accept) begin
            r_ext <= w_ext_nxt;
            r_idx <= w_idx_nxt;
            r_cnt <= w_cnt_nxt;
            if (r_state == S_IDLE) begin
              r_mode_max <= smax & ~smin;
            end
            if (w_end) begin
              r_res_low <= w_ext_nxt;
              r_res_idx <= w_idx_nxt;
              r_res_cnt <= w_cnt_nxt;
              r_state   <= S_HOLD;
            end else begin
              r_state   <= S_ACC;
            end
          end
        end
        S_HOLD: begin
          // No input is taken here; the next frame can start only on the
          // cycle after the result is delivered.
          if (w_deliver) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mminmax_stream.sv
module tb_mminmax_stream;

  logic       clk;
  logic       rst_n;
  logic       smin;
  logic       smax;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       u_in_ready, u_out_valid;
  logic [3:0] u_res_high, u_res_low;
  logic [2:0] u_res_idx;
  logic [3:0] u_res_cnt;

  logic       s_in_ready, s_out_valid;
  logic [3:0] s_res_high, s_res_low;
  logic [2:0] s_res_idx;
  logic [3:0] s_res_cnt;

  int n_cmp;
  int n_err;

  mminmax_stream #(.WIDTH(4), .DEPTH(8), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .smin(smin), .smax(smax),
    .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(u_out_valid), .out_ready(out_ready),
    .res_high(u_res_high), .res_low(u_res_low), .res_idx(u_res_idx), .res_cnt(u_res_cnt)
  );

  mminmax_stream #(.WIDTH(4), .DEPTH(8), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .smin(smin), .smax(smax),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .res_high(s_res_high), .res_low(s_res_low), .res_idx(s_res_idx), .res_cnt(s_res_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel_s;     // 1: check the SIGNED=1 instance
    logic        smin;
    logic        smax;
    int          n;
    logic        use_last;
    logic [31:0] data;      // sample i in data[4*i +: 4]
    int          e_low;
    int          e_idx;
    int          e_cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_sample(input logic [3:0] d, input logic last,
                              input logic mn, input logic mx);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    smin     = mn;
    smax     = mx;
  endtask

  // Called on the negedge right after the final sample's accepting edge.
  task automatic check_hold(input logic sel, input string tag,
                            input int e_low, input int e_idx, input int e_cnt);
    chk({tag, ".out_valid"}, sel ? int'(s_out_valid) : int'(u_out_valid), 1);
    chk({tag, ".in_ready"},  sel ? int'(s_in_ready)  : int'(u_in_ready),  0);
    chk({tag, ".res_low"},   sel ? int'(s_res_low)   : int'(u_res_low),   e_low);
    chk({tag, ".res_idx"},   sel ? int'(s_res_idx)   : int'(u_res_idx),   e_idx);
    chk({tag, ".res_cnt"},   sel ? int'(s_res_cnt)   : int'(u_res_cnt),   e_cnt);
    chk({tag, ".res_high"},  sel ? int'(s_res_high)  : int'(u_res_high),  0);
  endtask

  task automatic deliver(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".out_valid_after"}, int'(u_out_valid), 0);
    chk({tag, ".in_ready_after"},  int'(u_in_ready),  1);
  endtask

  task automatic end_frame();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0; smin = 1'b0; smax = 1'b0; in_valid = 1'b0;
    in_data = 4'd0; in_last = 1'b0; out_ready = 1'b0;

    //            sel  smin smax n  last data           low idx cnt
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8, 1'b0, 32'h815C3739,  1, 6, 8};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 3, 1'b1, 32'h00000FF4, 15, 1, 3};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 3, 1'b1, 32'h00000555,  5, 0, 3};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8, 1'b0, 32'h76543210,  7, 7, 8};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 32'h0000000A, 10, 0, 1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 3, 1'b1, 32'h00000927,  2, 1, 3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4, 1'b1, 32'h00003366,  3, 2, 4};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 4, 1'b1, 32'h0000E0F8, 15, 1, 4};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 32'h000078E3,  8, 2, 4};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 4, 1'b1, 32'h000078E3,  7, 3, 4};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4, 1'b1, 32'h000078E3,  3, 0, 4};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 4, 1'b1, 32'h0000E0F8,  0, 2, 4};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8, 1'b0, 32'h11234567,  1, 6, 8};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8, 1'b1, 32'h33333333,  3, 0, 8};

    repeat (2) @(negedge clk);
    chk("reset.out_valid", int'(u_out_valid), 0);
    chk("reset.in_ready",  int'(u_in_ready),  1);
    chk("reset.res_low",   int'(u_res_low),   0);
    chk("reset.res_idx",   int'(u_res_idx),   0);
    chk("reset.res_cnt",   int'(u_res_cnt),   0);
    chk("reset.res_high",  int'(u_res_high),  0);
    rst_n = 1'b1;

    for (int v = 0; v < 14; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        drive_sample(vecs[v].data[4*i +: 4], vecs[v].use_last && (i == vecs[v].n - 1),
                     vecs[v].smin, vecs[v].smax);
      end
      end_frame();
      check_hold(vecs[v].sel_s, $sformatf("vec%0d", v),
                 vecs[v].e_low, vecs[v].e_idx, vecs[v].e_cnt);
      deliver($sformatf("vec%0d", v));
    end

    // Backpressure: result and in_ready must hold while out_ready stays low,
    // and offered samples during the hold are ignored.
    drive_sample(4'd1, 1'b0, 1'b0, 1'b1);
    drive_sample(4'd2, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    in_data = 4'd15;
    in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_hold(1'b0, $sformatf("bp%0d", c), 2, 1, 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    deliver("bp");
    chk("bp.retain_low", int'(u_res_low), 2);
    chk("bp.retain_cnt", int'(u_res_cnt), 2);

    // Mode change after the first sample is ignored
    drive_sample(4'd5, 1'b0, 1'b1, 1'b0);
    drive_sample(4'd9, 1'b0, 1'b0, 1'b1);
    drive_sample(4'd2, 1'b1, 1'b0, 1'b1);
    end_frame();
    check_hold(1'b0, "toggle", 2, 2, 3);
    deliver("toggle");
    drive_sample(4'd9, 1'b0, 1'b0, 1'b1);
    drive_sample(4'd2, 1'b1, 1'b0, 1'b1);
    end_frame();
    check_hold(1'b0, "after_toggle", 9, 0, 2);
    deliver("after_toggle");

    // Reset in the middle of a frame discards it and clears the results
    drive_sample(4'd1, 1'b0, 1'b1, 1'b0);
    drive_sample(4'd2, 1'b0, 1'b1, 1'b0);
    drive_sample(4'd3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.out_valid", int'(u_out_valid), 0);
    chk("midrst.in_ready",  int'(u_in_ready),  1);
    chk("midrst.res_low",   int'(u_res_low),   0);
    chk("midrst.res_idx",   int'(u_res_idx),   0);
    chk("midrst.res_cnt",   int'(u_res_cnt),   0);
    drive_sample(4'd6, 1'b0, 1'b1, 1'b0);
    drive_sample(4'd2, 1'b1, 1'b1, 1'b0);
    end_frame();
    check_hold(1'b0, "post_rst", 2, 1, 2);
    deliver("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
